// File: rtl/pixel_pkg.sv
// Shared types and defaults for the pixel pair aligner.
package pixel_pkg;

  localparam int PIX_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DONE
  } align_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Small per-stream pixel FIFO; dout always shows the head entry.
module pixel_fifo #(
  parameter int PIX_W = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [PIX_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  // full/empty come from the registered count only, so ready never sees a same-cycle pop
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/pixel_pair_aligner.sv
// Pairs two pixel streams in arrival order and presents registered operand pairs with position flags.
// Optional PAIR_STATS_EN adds pair_cnt / stall_cnt outputs.
module pixel_pair_aligner
  import pixel_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int DEPTH = 4,
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             a_valid,
  input  logic [PIX_W-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [PIX_W-1:0] b_data,
  output logic             b_ready,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [PIX_W-1:0] op_a,
  output logic [PIX_W-1:0] op_b,
  output logic             op_sol,
  output logic             op_eol,
  output logic             op_eof,
  output logic             frame_done
`ifdef PAIR_STATS_EN
  ,
  output logic [15:0]      pair_cnt,
  output logic [15:0]      stall_cnt
`endif
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  align_state_t     state_q, state_d;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic [PIX_W-1:0] a_dout, b_dout;
  logic             a_empty, a_full, b_empty, b_full;
  logic             col_last, row_last;
  logic             accept, load;

  assign a_ready  = !a_full;
  assign b_ready  = !b_full;
  assign col_last = (col_q == COL_W'(IMG_W - 1));
  assign row_last = (row_q == ROW_W'(IMG_H - 1));
  assign accept   = op_valid && op_ready;
  // once the eof pair sits in the output register the frame is closed to further loads
  assign load     = (state_q == ST_STREAM) && !a_empty && !b_empty &&
                    (!op_valid || op_ready) && !(op_valid && op_eof);

  pixel_fifo #(.PIX_W(PIX_W), .DEPTH(DEPTH)) u_fifo_a (
    .clk(clk), .rst_n(rst_n), .push(a_valid), .pop(load),
    .din(a_data), .dout(a_dout), .empty(a_empty), .full(a_full)
  );

  pixel_fifo #(.PIX_W(PIX_W), .DEPTH(DEPTH)) u_fifo_b (
    .clk(clk), .rst_n(rst_n), .push(b_valid), .pop(load),
    .din(b_data), .dout(b_dout), .empty(b_empty), .full(b_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_STREAM;
      ST_STREAM: if (accept && op_eof) state_d = ST_DONE;
      ST_DONE: begin
        frame_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q    <= '0;
      row_q    <= '0;
      op_valid <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_sol   <= 1'b0;
      op_eol   <= 1'b0;
      op_eof   <= 1'b0;
    end else if (load) begin
      op_valid <= 1'b1;
      op_a     <= a_dout;
      op_b     <= b_dout;
      op_sol   <= (col_q == '0);
      op_eol   <= col_last;
      op_eof   <= col_last && row_last;
      if (col_last) begin
        col_q <= '0;
        row_q <= row_last ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end else if (accept) begin
      op_valid <= 1'b0;
    end
  end

`ifdef PAIR_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_cnt  <= '0;
      stall_cnt <= '0;
    end else if (state_q == ST_IDLE && start) begin
      pair_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept) pair_cnt <= pair_cnt + 1'b1;
      if (state_q == ST_STREAM && (a_empty ^ b_empty) && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_pair_aligner.sv
// Directed bench for pixel_pair_aligner with a 4x2 frame and 4-deep FIFOs.
module tb_pixel_pair_aligner;
  import pixel_pkg::*;

  logic       clk, rst_n, start;
  logic       a_valid, b_valid, a_ready, b_ready;
  logic [7:0] a_data, b_data, op_a, op_b;
  logic       op_valid, op_ready, op_sol, op_eol, op_eof, frame_done;
`ifdef PAIR_STATS_EN
  logic [15:0] pair_cnt, stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pixel_pair_aligner #(.PIX_W(8), .DEPTH(4), .IMG_W(4), .IMG_H(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .op_sol(op_sol), .op_eol(op_eol), .op_eof(op_eof), .frame_done(frame_done)
`ifdef PAIR_STATS_EN
    , .pair_cnt(pair_cnt), .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    start    = 1'b0;
    a_valid  = 1'b0;
    b_valid  = 1'b0;
    a_data   = '0;
    b_data   = '0;
    op_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  logic [7:0] sol_tab, eol_tab, eof_tab;

  initial begin
    sol_tab = 8'b0001_0001;
    eol_tab = 8'b1000_1000;
    eof_tab = 8'b1000_0000;

    // reset state
    do_reset();
    check("rst_op_valid", op_valid, 0);
    check("rst_op_a", op_a, 0);
    check("rst_op_b", op_b, 0);
    check("rst_flags", {op_sol, op_eol, op_eof}, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_a_ready", a_ready, 1);
    check("rst_b_ready", b_ready, 1);
    check("rst_state", dut.state_q, ST_IDLE);

    // scenario 1: basic pairing and latency
    op_ready = 1'b1;
    start = 1'b1; a_valid = 1'b1; a_data = 8'd16; b_valid = 1'b1; b_data = 8'd15;
    tick();
    start = 1'b0;
    check("s1_lat_n1", op_valid, 0);
    a_data = 8'd11; b_data = 8'd21;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    check("s1_lat_n2", op_valid, 1);
    check("s1_p0", {op_a, op_b}, {8'd16, 8'd15});
    check("s1_p0_sol", op_sol, 1);
    tick();
    check("s1_p1_valid", op_valid, 1);
    check("s1_p1", {op_a, op_b}, {8'd11, 8'd21});
    check("s1_p1_sol", op_sol, 0);
    tick();
    check("s1_drain", op_valid, 0);

    // scenario 2: full 4x2 frame, flags and frame_done
    do_reset();
    op_ready = 1'b1;
    for (int s = 0; s < 14; s++) begin
      tick();
      check("s2_valid", op_valid, (s >= 2 && s <= 9));
      if (s >= 2 && s <= 9) begin
        check("s2_data", {op_a, op_b}, {8'(s - 1), 8'(s + 98)});
        check("s2_sol", op_sol, sol_tab[s-2]);
        check("s2_eol", op_eol, eol_tab[s-2]);
        check("s2_eof", op_eof, eof_tab[s-2]);
      end
      check("s2_frame_done", frame_done, (s == 10));
      if (s == 11) check("s2_idle", dut.state_q, ST_IDLE);
      start = (s == 0);
      if (s < 8) begin
        a_valid = 1'b1; a_data = 8'(s + 1);
        b_valid = 1'b1; b_data = 8'(s + 100);
      end else begin
        a_valid = 1'b0; b_valid = 1'b0;
      end
    end

    // scenario 3: one-sided fill, then B catches up
    do_reset();
    op_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("s3_a_ready", a_ready, (i < 4));
      check("s3_no_valid", op_valid, 0);
      start = (i == 0);
      a_valid = 1'b1; a_data = 8'(10 + i);
    end
    for (int j = 0; j < 8; j++) begin
      tick();
      if (j == 0) check("s3_a_full", a_ready, 0);
      check("s3_valid", op_valid, (j >= 2 && j <= 5));
      if (j >= 2 && j <= 5) begin
        check("s3_data", {op_a, op_b}, {8'(8 + j), 8'(j - 1)});
        check("s3_sol", op_sol, (j == 2));
        check("s3_eol", op_eol, (j == 5));
      end
      start = 1'b0;
      a_valid = 1'b0;
      b_valid = (j < 4); b_data = 8'(j + 1);
    end
`ifdef PAIR_STATS_EN
    check("s6_stall_cnt", stall_cnt, 6);
    check("s6_pair_cnt", pair_cnt, 4);
`endif

    // scenario 4: backpressure holds the output register
    do_reset();
    op_ready = 1'b0;
    for (int s = 0; s < 11; s++) begin
      tick();
      if (s >= 2 && s <= 7) begin
        check("s4_hold_valid", op_valid, 1);
        check("s4_hold_data", {op_a, op_b}, {8'd50, 8'd60});
        check("s4_hold_flags", {op_sol, op_eol, op_eof}, 3'b100);
      end
      if (s >= 3 && s <= 7) begin
        check("s4_fifo_a_cnt", dut.u_fifo_a.count_q, 2);
        check("s4_fifo_b_cnt", dut.u_fifo_b.count_q, 2);
      end
      if (s == 8) check("s4_p1", {op_valid, op_a, op_b}, {1'b1, 8'd51, 8'd61});
      if (s == 9) check("s4_p2", {op_valid, op_a, op_b}, {1'b1, 8'd52, 8'd62});
      if (s == 10) check("s4_drain", op_valid, 0);
      start = (s == 0);
      op_ready = (s >= 7);
      a_valid = (s < 3); a_data = 8'(50 + s);
      b_valid = (s < 3); b_data = 8'(60 + s);
    end

    // scenario 5: reset mid-frame
    do_reset();
    op_ready = 1'b1;
    for (int s = 0; s < 6; s++) begin
      tick();
      if (s >= 2) check("s5_pre_data", op_a, 8'(s - 1));
      start = (s == 0);
      a_valid = 1'b1; a_data = 8'(s + 1);
      b_valid = 1'b1; b_data = 8'(s + 100);
    end
    #2;
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    #1;
    check("s5_async_valid", op_valid, 0);
    check("s5_async_data", {op_a, op_b}, 0);
    check("s5_async_flags", {op_sol, op_eol, op_eof}, 0);
    check("s5_async_ready", {a_ready, b_ready}, 2'b11);
    check("s5_fifo_empty", {dut.u_fifo_a.empty, dut.u_fifo_b.empty}, 2'b11);
    check("s5_state", dut.state_q, ST_IDLE);
    for (int s = 0; s < 3; s++) begin
      tick();
      check("s5_no_done_rst", frame_done, 0);
    end
    rst_n = 1'b1;
    start = 1'b1; a_valid = 1'b1; a_data = 8'd77; b_valid = 1'b1; b_data = 8'd88;
    tick();
    start = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    check("s5_no_done", frame_done, 0);
    tick();
    check("s5_new_valid", op_valid, 1);
    check("s5_new_data", {op_a, op_b}, {8'd77, 8'd88});
    check("s5_new_sol", op_sol, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
